// File: rtl/bcd_timer_ctrl_if.sv
// bcd_timer_ctrl_if: request/feedback bundle between a host, the timer
// controller and the external 2-digit BCD counter it sequences.
interface bcd_timer_ctrl_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       dir;
    logic [7:0] limit;
    logic [3:0] q0;
    logic [3:0] q1;
    logic       tc;
    logic       mode;
    logic       count;
    logic       cnt_clr_n;
    logic       busy;
    logic       done;

    // Host side plus counter feedback
    modport master (
        output start, stop, clear, dir, limit, q0, q1, tc,
        input  mode, count, cnt_clr_n, busy, done
    );

    // Controller side
    modport slave (
        input  start, stop, clear, dir, limit, q0, q1, tc,
        output mode, count, cnt_clr_n, busy, done
    );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: run/pause/done sequencer for an external 2-digit BCD counter.
// Emits one count-enable pulse every DIV RUN cycles until the counter reads
// the latched limit or raises terminal count. All outputs are registered.
// Build option: BCD_CTRL_AUTORELOAD_EN -- DONE lasts one cycle, strobes the
// counter clear and re-enters RUN with the same mode and limit.
module bcd_timer_ctrl #(
    parameter int unsigned DIV = 10
) (
    input  logic            clk,
    input  logic            rstn,
    bcd_timer_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [7:0] PSC_LAST = 8'(DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] psc_q, psc_d;
    logic [7:0] limit_q, limit_d;
    logic       mode_q, mode_d;
    logic       count_q, count_d;
    logic       clr_n_q, clr_n_d;
    logic       busy_q, done_q;

    logic [7:0] q_now, q_eff;
    logic       tc_eff, wrap, at_limit;

    // One BCD step in the counter's current direction (wraps 99<->00)
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic down);
        logic [3:0] t, o;
        t = v[7:4];
        o = v[3:0];
        if (!down) begin
            if (o >= 4'd9) begin
                o = 4'd0;
                t = (t >= 4'd9) ? 4'd0 : t + 4'd1;
            end else begin
                o = o + 4'd1;
            end
        end else begin
            if (o == 4'd0) begin
                o = 4'd9;
                t = (t == 4'd0) ? 4'd9 : t - 4'd1;
            end else begin
                o = o - 4'd1;
            end
        end
        return {t, o};
    endfunction

    // Feedback lags our registered pulse by a cycle; look through a pulse
    // already on the wire so back-to-back pulses (DIV=1) never overshoot.
    always_comb begin
        q_now    = {bus.q1, bus.q0};
        q_eff    = count_q ? bcd_step(q_now, mode_q) : q_now;
        tc_eff   = count_q ? (mode_q ? (q_eff == 8'h00) : (q_eff == 8'h99)) : bus.tc;
        wrap     = (psc_q == PSC_LAST);
        at_limit = (q_eff == limit_q);
    end

    // Next-state and registered-output decode; clear beats everything
    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        count_d = 1'b0;
        clr_n_d = 1'b1;
        if (bus.clear) begin
            state_d = IDLE;
            psc_d   = 8'd0;
            clr_n_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        mode_d  = bus.dir;
                        limit_d = bus.limit;
                        psc_d   = 8'd0;
                    end
                end
                RUN: begin
                    // Terminal conditions win over stop so a finished run is never parked
                    if (at_limit || (wrap && tc_eff)) begin
                        state_d = DONE;
`ifdef BCD_CTRL_AUTORELOAD_EN
                        clr_n_d = 1'b0;
`endif
                    end else if (bus.stop) begin
                        state_d = PAUSE;
                    end else begin
                        psc_d   = wrap ? 8'd0 : psc_q + 8'd1;
                        count_d = wrap;
                    end
                end
                PAUSE: begin
                    if (bus.start) state_d = RUN;
                end
                DONE: begin
`ifdef BCD_CTRL_AUTORELOAD_EN
                    state_d = RUN;
                    psc_d   = 8'd0;
`else
                    state_d = DONE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            psc_q   <= 8'd0;
            limit_q <= 8'd0;
            mode_q  <= 1'b0;
            count_q <= 1'b0;
            clr_n_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            clr_n_q <= clr_n_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.mode      = mode_q;
    assign bus.count     = count_q;
    assign bus.cnt_clr_n = clr_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter DIV, default 10: clock cycles per count pulse; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  single-cycle request: begin or resume counting.
REQ-005 stop  input  1  single-cycle request: pause counting.
REQ-006 clear  input  1  single-cycle request: abort, clear the counter and return to idle.
REQ-007 dir  input  1  direction request: 0 = up, 1 = down; sampled only on start from IDLE.
REQ-008 limit  input  8  target value, two BCD digits {tens, ones}; sampled only on start from IDLE.
REQ-009 q0, q1  input  4 each  ones and tens digits fed back from the 2-digit BCD counter.
REQ-010 tc  input  1  terminal-count carry/borrow fed back from the counter's tens stage.
REQ-011 mode  output  1  direction driven to the counter's mode input.
REQ-012 count  output  1  one-cycle count-enable pulse to the counter's count input.
REQ-013 cnt_clr_n  output  1  active-low one-cycle clear strobe to the counter.
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  high while in DONE.

Function
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE and DONE; all outputs SHALL be registered.
REQ-017 Request priority SHALL be clear > stop > start when several are asserted in the same cycle.
REQ-018 A clear in any state SHALL drive cnt_clr_n low for exactly one cycle, zero the prescaler and enter IDLE.
REQ-019 A start in IDLE SHALL latch dir into mode, latch limit, zero the prescaler and enter RUN.
REQ-020 A start in PAUSE SHALL enter RUN with the prescaler and mode unchanged; dir and limit SHALL be ignored.
REQ-021 A stop in RUN SHALL enter PAUSE with the prescaler frozen; a stop in any other state SHALL be ignored.
REQ-022 In RUN the prescaler SHALL increment each cycle; at the value DIV-1 it SHALL wrap to 0 and assert count for one cycle.
REQ-023 When DIV = 1, count SHALL be high on every RUN cycle.
REQ-024 In RUN, if {q1,q0} equals the latched limit, the FSM SHALL enter DONE and suppress count in that cycle.
REQ-025 In RUN, if tc is high on a cycle where count would be issued, count SHALL be suppressed and the FSM SHALL enter DONE (saturation guard, which covers non-BCD limits).
REQ-026 In DONE, count SHALL remain low, and start and stop SHALL be ignored.
REQ-027 count SHALL never be high outside RUN, and never in the same cycle that cnt_clr_n is low.

Reset
REQ-028 While rstn is low: state = IDLE, prescaler = 0, latched limit = 0, mode = 0, count = 0, cnt_clr_n = 1, busy = 0, done = 0.
REQ-029 Reset asserted mid-RUN SHALL abort immediately with no further count pulse; operation SHALL resume only on a new start after rstn deasserts.

Configuration
REQ-030 Macro BCD_CTRL_AUTORELOAD_EN, when defined: DONE SHALL last one cycle with done high and cnt_clr_n low, then enter RUN with the prescaler at 0 and mode and limit retained.
REQ-031 Macro BCD_CTRL_AUTORELOAD_EN, when undefined: DONE SHALL hold until clear or reset.

Verification
REQ-032 DIV=4, dir=0, limit=8'h12, start from q=00 -> count pulses every 4th cycle; done asserted once q reads 12; exactly 12 pulses issued.
REQ-033 DIV=4, dir=1, limit=8'h05, counter preset to 20 -> 15 pulses, mode=1 throughout, then DONE.
REQ-034 Stop after 3 pulses, hold PAUSE 10 cycles, then start -> no pulses during PAUSE; next pulse arrives after the frozen prescaler remainder completes.
REQ-035 clear, stop and start asserted together in RUN -> cnt_clr_n low 1 cycle, state IDLE, count low.
REQ-036 limit=8'hA0 (non-BCD), dir=0 -> counting stops at q=99 when tc rises; DONE entered with no wrap to 00.
REQ-037 With BCD_CTRL_AUTORELOAD_EN and limit=8'h03 -> done pulses 1 cycle every 3 counts, with a clear strobe each time; without the macro, done stays high.
